// File: rtl/mem_pkg.sv
// Shared definitions for the load/store unit: access-size codes, FSM states,
// and the lane extract/merge helpers used by the datapath.
package mem_pkg;

  localparam logic [1:0] SZ_BYTE = 2'd0;
  localparam logic [1:0] SZ_HALF = 2'd1;
  localparam logic [1:0] SZ_WORD = 2'd2;
  localparam logic [1:0] SZ_ILL  = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_WRITE  = 2'd2,
    ST_RESP   = 2'd3
  } state_e;

  // Pull the addressed byte/half out of a word and sign- or zero-extend it.
  function automatic logic [31:0] lane_extract(input logic [31:0] word,
                                               input logic [1:0]  lo,
                                               input logic [1:0]  size,
                                               input logic        uns);
    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] res;
    b = word[{lo, 3'b000} +: 8];
    h = word[{lo[1], 4'b0000} +: 16];
    case (size)
      SZ_BYTE: begin
        if (uns) begin
          res = {24'd0, b};
        end else begin
          res = {{24{b[7]}}, b};
        end
      end
      SZ_HALF: begin
        if (uns) begin
          res = {16'd0, h};
        end else begin
          res = {{16{h[15]}}, h};
        end
      end
      SZ_WORD: res = word;
      default: res = 32'd0;
    endcase
    return res;
  endfunction

  // Replace the addressed byte/half of a word with right-aligned store data.
  function automatic logic [31:0] lane_merge(input logic [31:0] word,
                                             input logic [31:0] wdata,
                                             input logic [1:0]  lo,
                                             input logic [1:0]  size);
    logic [31:0] res;
    res = word;
    case (size)
      SZ_BYTE: res[{lo, 3'b000} +: 8]     = wdata[7:0];
      SZ_HALF: res[{lo[1], 4'b0000} +: 16] = wdata[15:0];
      SZ_WORD: res = wdata;
      default: res = word;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/mau_lane_align.sv
// Combinational lane alignment: load-side extract/extend and store-side merge.
module mau_lane_align
  import mem_pkg::*;
(
  input  logic [31:0] rd_word,
  input  logic [31:0] merge_word,
  input  logic [31:0] wdata,
  input  logic [1:0]  lo,
  input  logic [1:0]  size,
  input  logic        uns,
  output logic [31:0] ext_data,
  output logic [31:0] merged_data
);

  assign ext_data    = lane_extract(rd_word, lo, size, uns);
  assign merged_data = lane_merge(merge_word, wdata, lo, size);

endmodule

// File: rtl/mem_access_unit.sv
// Load/store unit: accepts byte-addressed requests, checks them, runs word
// memory cycles (read-modify-write for sub-word stores) and returns a response.
module mem_access_unit
  import mem_pkg::*;
#(
  parameter int unsigned ADDR_W       = 12,
  parameter bit          ERR_ON_RANGE = 1'b1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [1:0]  req_size,
  input  logic        req_unsigned,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err,
  output logic [31:0] mem_a,
  output logic [31:0] mem_wd,
  output logic        mem_we,
  input  logic [31:0] mem_rd
);

  state_e              state_q, state_d;
  logic                we_q, we_d;
  logic [1:0]          size_q, size_d;
  logic                uns_q, uns_d;
  logic [ADDR_W+1:0]   addr_q, addr_d;
  logic [31:0]         wdata_q, wdata_d;
  logic [31:0]         merge_q, merge_d;
  logic [31:0]         rdata_q, rdata_d;
  logic                err_q, err_d;

  logic                range_err_s;
  logic                req_err_s;
  logic [31:0]         ext_s;
  logic [31:0]         merged_s;

  mau_lane_align u_align (
    .rd_word     (mem_rd),
    .merge_word  (merge_q),
    .wdata       (wdata_q),
    .lo          (addr_q[1:0]),
    .size        (size_q),
    .uns         (uns_q),
    .ext_data    (ext_s),
    .merged_data (merged_s)
  );

  // Classify the incoming request: illegal size, misalignment, out of range.
  always_comb begin
    range_err_s = 1'b0;
    if (ERR_ON_RANGE) begin
      range_err_s = ((req_addr >> (ADDR_W + 2)) != 32'd0);
    end else begin
      range_err_s = 1'b0;
    end
    req_err_s = (req_size == SZ_ILL) ||
                ((req_size == SZ_HALF) && (req_addr[0] != 1'b0)) ||
                ((req_size == SZ_WORD) && (req_addr[1:0] != 2'b00)) ||
                range_err_s;
  end

  // Next-state and register updates for the access sequence.
  always_comb begin
    state_d = state_q;
    we_d    = we_q;
    size_d  = size_q;
    uns_d   = uns_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    merge_d = merge_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    case (state_q)
      ST_IDLE: begin
        if (req_valid) begin
          we_d    = req_we;
          size_d  = req_size;
          uns_d   = req_unsigned;
          addr_d  = req_addr[ADDR_W+1:0];
          wdata_d = req_wdata;
          rdata_d = 32'd0;
          err_d   = req_err_s;
          if (req_err_s) begin
            state_d = ST_RESP;
          end else begin
            state_d = ST_ACCESS;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_ACCESS: begin
        if (!we_q) begin
          rdata_d = ext_s;
          state_d = ST_RESP;
        end else if (size_q == SZ_WORD) begin
          state_d = ST_RESP;
        end else begin
          merge_d = mem_rd;
          state_d = ST_WRITE;
        end
      end
      ST_WRITE: begin
        state_d = ST_RESP;
      end
      ST_RESP: begin
        if (rsp_ready) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_RESP;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and request registers; reset aborts any access in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      we_q    <= 1'b0;
      size_q  <= 2'd0;
      uns_q   <= 1'b0;
      addr_q  <= '0;
      wdata_q <= 32'd0;
      merge_q <= 32'd0;
      rdata_q <= 32'd0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      we_q    <= we_d;
      size_q  <= size_d;
      uns_q   <= uns_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      merge_q <= merge_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  // Memory port decoded from state so a reset drops the write enable at once.
  always_comb begin
    mem_we = 1'b0;
    mem_wd = 32'd0;
    mem_a  = 32'd0;
    case (state_q)
      ST_ACCESS: begin
        mem_a = {{(32 - ADDR_W){1'b0}}, addr_q[ADDR_W+1:2]};
        if (we_q && (size_q == SZ_WORD)) begin
          mem_we = 1'b1;
          mem_wd = wdata_q;
        end else begin
          mem_we = 1'b0;
          mem_wd = 32'd0;
        end
      end
      ST_WRITE: begin
        mem_a  = {{(32 - ADDR_W){1'b0}}, addr_q[ADDR_W+1:2]};
        mem_we = 1'b1;
        mem_wd = merged_s;
      end
      default: begin
        mem_we = 1'b0;
        mem_wd = 32'd0;
        mem_a  = 32'd0;
      end
    endcase
  end

  assign req_ready = (state_q == ST_IDLE);
  assign rsp_valid = (state_q == ST_RESP);
  assign rsp_rdata = rdata_q;
  assign rsp_err   = err_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// Randomized self-checking bench for mem_access_unit against a byte-level
// reference model of the data memory and the request rules.
module tb_mem_access_unit;

  logic        clk;
  logic        rst_n;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [1:0]  req_size;
  logic        req_unsigned;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic [31:0] mem_a;
  logic [31:0] mem_wd;
  logic        mem_we;
  logic [31:0] mem_rd;

  int total = 0;
  int bad   = 0;

  logic [31:0] mem     [0:4095];
  logic [31:0] ref_mem [0:4095];

  mem_access_unit #(.ADDR_W(12), .ERR_ON_RANGE(1'b1)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_we       (req_we),
    .req_size     (req_size),
    .req_unsigned (req_unsigned),
    .req_addr     (req_addr),
    .req_wdata    (req_wdata),
    .rsp_valid    (rsp_valid),
    .rsp_ready    (rsp_ready),
    .rsp_rdata    (rsp_rdata),
    .rsp_err      (rsp_err),
    .mem_a        (mem_a),
    .mem_wd       (mem_wd),
    .mem_we       (mem_we),
    .mem_rd       (mem_rd)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Word-addressed data memory: combinational read, posedge write.
  always @(posedge clk) begin
    if (mem_we) mem[mem_a[11:0]] <= mem_wd;
  end
  assign mem_rd = mem[mem_a[11:0]];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic model_err(input logic [1:0] sz, input logic [31:0] addr);
    int unsigned align;
    align = 1 << sz;
    return (sz == 2'd3) || ((addr % align) != 0) || (addr >= 32'h0000_4000);
  endfunction

  function automatic logic [31:0] model_load(input logic [1:0] sz, input logic uns,
                                             input logic [31:0] addr);
    logic [31:0] w;
    logic [31:0] v;
    int unsigned sh;
    w  = ref_mem[(addr / 4) % 4096];
    sh = (addr % 4) * 8;
    if (sz == 2'd0) begin
      v = (w >> sh) & 32'hFF;
      if (!uns && v >= 32'd128) v = v + 32'hFFFF_FF00;
    end else if (sz == 2'd1) begin
      v = (w >> sh) & 32'hFFFF;
      if (!uns && v >= 32'd32768) v = v + 32'hFFFF_0000;
    end else begin
      v = w;
    end
    return v;
  endfunction

  function automatic logic [31:0] model_store(input logic [31:0] old, input logic [1:0] sz,
                                              input logic [31:0] addr, input logic [31:0] wd);
    logic [31:0] mask;
    int unsigned sh;
    sh   = (addr % 4) * 8;
    mask = (sz == 2'd0) ? 32'hFF : (sz == 2'd1) ? 32'hFFFF : 32'hFFFF_FFFF;
    return (old & ~(mask << sh)) | ((wd & mask) << sh);
  endfunction

  // One request: drive, watch the response, compare with the model.
  task automatic run_req(input logic we, input logic [1:0] sz, input logic uns,
                         input logic [31:0] addr, input logic [31:0] wd, input int bp,
                         output logic [31:0] got);
    logic        e_err;
    logic [31:0] e_rdata;
    int          e_lat;
    int          e_wr;
    int          cyc;
    int          wr_cnt;
    int          wr_cyc;
    logic        seen;
    logic        hi_seen;
    int unsigned idx;

    e_err   = model_err(sz, addr);
    e_rdata = (e_err || we) ? 32'd0 : model_load(sz, uns, addr);
    e_lat   = e_err ? 1 : ((we && sz != 2'd2) ? 3 : 2);
    e_wr    = (we && !e_err) ? 1 : 0;

    @(negedge clk);
    chk("req_ready_idle", {31'd0, req_ready}, 32'd1);
    req_valid    = 1'b1;
    req_we       = we;
    req_size     = sz;
    req_unsigned = uns;
    req_addr     = addr;
    req_wdata    = wd;
    rsp_ready    = (bp == 0);
    @(posedge clk);
    #1;
    // Garbage while busy must be ignored.
    req_valid    = 1'($urandom % 2);
    req_we       = 1'($urandom % 2);
    req_size     = 2'($urandom % 4);
    req_unsigned = 1'($urandom % 2);
    req_addr     = $urandom % 64;
    req_wdata    = $urandom;

    cyc = 0; wr_cnt = 0; wr_cyc = 0; seen = 1'b0; hi_seen = 1'b0;
    while (!seen && cyc < 20) begin
      @(negedge clk);
      cyc++;
      hi_seen = hi_seen | (|mem_a[31:12]);
      if (mem_we) begin
        wr_cnt++;
        wr_cyc = cyc;
      end
      if (rsp_valid) seen = 1'b1;
    end
    req_valid = 1'b0;
    got = rsp_rdata;
    chk("rsp_seen", {31'd0, seen}, 32'd1);
    chk("latency", 32'(cyc), 32'(e_lat));
    chk("rdata", rsp_rdata, e_rdata);
    chk("err", {31'd0, rsp_err}, {31'd0, e_err});
    chk("req_ready_busy", {31'd0, req_ready}, 32'd0);
    chk("wr_count", 32'(wr_cnt), 32'(e_wr));
    chk("mem_a_hi", {31'd0, hi_seen}, 32'd0);
    if (wr_cnt > 0) chk("wr_cycle", 32'(wr_cyc), 32'(e_lat - 1));

    for (int i = 0; i < bp; i++) begin
      @(negedge clk);
      chk("bp_valid", {31'd0, rsp_valid}, 32'd1);
      chk("bp_rdata", rsp_rdata, got);
      chk("bp_err", {31'd0, rsp_err}, {31'd0, e_err});
      chk("bp_req_ready", {31'd0, req_ready}, 32'd0);
      chk("bp_mem_we", {31'd0, mem_we}, 32'd0);
    end
    rsp_ready = 1'b1;

    if (we && !e_err) begin
      idx = (addr / 4) % 4096;
      ref_mem[idx] = model_store(ref_mem[idx], sz, addr, wd);
      chk("mem_word", mem[idx], ref_mem[idx]);
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [31:0] got;
    logic        we;
    logic [1:0]  sz;
    logic [31:0] addr;

    rst_n = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_size = 2'd0;
    req_unsigned = 1'b0; req_addr = 32'd0; req_wdata = 32'd0; rsp_ready = 1'b1;
    for (int i = 0; i < 4096; i++) ref_mem[i] = 32'd0;

    repeat (3) @(negedge clk);
    chk("rst_req_ready", {31'd0, req_ready}, 32'd1);
    chk("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    chk("rst_rsp_err", {31'd0, rsp_err}, 32'd0);
    chk("rst_rsp_rdata", rsp_rdata, 32'd0);
    chk("rst_mem_we", {31'd0, mem_we}, 32'd0);
    chk("rst_mem_a", mem_a, 32'd0);
    chk("rst_mem_wd", mem_wd, 32'd0);
    rst_n = 1'b1;

    // Directed scenarios with hand-derived expectations.
    run_req(1'b1, 2'd2, 1'b0, 32'h10, 32'hDEADBEEF, 0, got);
    chk("sw_word4", mem[4], 32'hDEADBEEF);
    run_req(1'b0, 2'd2, 1'b0, 32'h10, 32'd0, 0, got);
    chk("lw_10", got, 32'hDEADBEEF);
    run_req(1'b1, 2'd0, 1'b0, 32'h11, 32'h55, 0, got);
    chk("sb_rmw_word4", mem[4], 32'hDEAD55EF);
    run_req(1'b0, 2'd0, 1'b0, 32'h13, 32'd0, 0, got);
    chk("lb_13", got, 32'hFFFFFFDE);
    run_req(1'b0, 2'd0, 1'b1, 32'h13, 32'd0, 0, got);
    chk("lbu_13", got, 32'h000000DE);
    run_req(1'b0, 2'd1, 1'b0, 32'h12, 32'd0, 0, got);
    chk("lh_12", got, 32'hFFFFDEAD);
    run_req(1'b0, 2'd1, 1'b1, 32'h12, 32'd0, 0, got);
    chk("lhu_12", got, 32'h0000DEAD);
    run_req(1'b0, 2'd2, 1'b0, 32'h12, 32'd0, 0, got);
    run_req(1'b1, 2'd1, 1'b0, 32'h13, 32'h1234, 0, got);
    run_req(1'b0, 2'd3, 1'b0, 32'h10, 32'd0, 0, got);
    run_req(1'b1, 2'd2, 1'b0, 32'h4000, 32'hCAFEF00D, 0, got);
    chk("range_word4", mem[4], 32'hDEAD55EF);

    // Backpressure, then a request right after the handshake.
    run_req(1'b0, 2'd2, 1'b0, 32'h10, 32'd0, 5, got);
    run_req(1'b0, 2'd0, 1'b1, 32'h10, 32'd0, 0, got);
    chk("after_bp_lbu", got, 32'h000000EF);

    // Seed the random working set.
    for (int i = 0; i < 16; i++) run_req(1'b1, 2'd2, 1'b0, 32'(i * 4), $urandom, 0, got);

    // Reset while the read-modify-write is in its write cycle.
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b1; req_size = 2'd0; req_unsigned = 1'b0;
    req_addr = 32'h21; req_wdata = 32'hAA;
    @(posedge clk);
    #1 req_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("rmw_we_in_write", {31'd0, mem_we}, 32'd1);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_mem_we", {31'd0, mem_we}, 32'd0);
    chk("mid_rst_req_ready", {31'd0, req_ready}, 32'd1);
    chk("mid_rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    chk("mid_rst_word8", mem[8], ref_mem[8]);
    run_req(1'b0, 2'd2, 1'b0, 32'h20, 32'd0, 0, got);

    // Random traffic over the working set plus occasional out-of-range hits.
    for (int n = 0; n < 80; n++) begin
      we   = 1'($urandom % 2);
      sz   = 2'($urandom % 4);
      addr = (($urandom % 12) == 0) ? (32'h4000 + ($urandom % 256)) : ($urandom % 64);
      run_req(we, sz, 1'($urandom % 2), addr, $urandom,
              (($urandom % 5) == 0) ? int'($urandom_range(1, 3)) : 0, got);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
